// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arbiter_if
//  Description : Bundle of the signals that connect dmem_arbiter to its two
//                requesters and to the single-ported DataMemory.
//                  Requester side : req/wr/addr/wdata in, ack/err out (per
//                                   port), shared rdata out.
//                  Memory side    : mem_address/mem_write_data/mem_write/
//                                   mem_read out, mem_read_data in.
//                Modport "slave" is the arbiter's view of the bundle.
//                Modport "master" is the surrounding system's view of the
//                bundle: the requesters plus the memory.
//  Revision    : 1.0 - initial release
// ============================================================================
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  // Port 0 (pipeline MEM stage)
  logic              req0;
  logic              wr0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0;
  logic              ack0;
  logic              err0;

  // Port 1 (secondary requester: loader / debug)
  logic              req1;
  logic              wr1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1;
  logic              ack1;
  logic              err1;

  // Read data shared by both ports
  logic [DATA_W-1:0] rdata;

  // DataMemory connection
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_write_data;
  logic              mem_write;
  logic              mem_read;
  logic [DATA_W-1:0] mem_read_data;

  modport slave (
    input  req0, wr0, addr0, wdata0,
    input  req1, wr1, addr1, wdata1,
    output ack0, err0, ack1, err1,
    output rdata,
    output mem_address, mem_write_data, mem_write, mem_read,
    input  mem_read_data
  );

  modport master (
    output req0, wr0, addr0, wdata0,
    output req1, wr1, addr1, wdata1,
    input  ack0, err0, ack1, err1,
    input  rdata,
    input  mem_address, mem_write_data, mem_write, mem_read,
    output mem_read_data
  );

endinterface : dmem_arbiter_if
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arbiter
//  Description : Round-robin two-port arbiter for the single-ported
//                DataMemory. One access at a time runs through a fixed
//                IDLE -> SERVE -> ACK sequence:
//                  IDLE  : pick a winner, latch a misalignment flag
//                  SERVE : drive the memory strobes for one cycle and
//                          capture read data on the closing edge
//                  ACK   : one-cycle ack (plus err) to the winner
//                Ports:
//                  clk  - system clock, rising edge active
//                  rst  - asynchronous active-high reset
//                  bus  - dmem_arbiter_if.slave (requesters + memory)
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  wire logic      clk,
  input  wire logic      rst,
  dmem_arbiter_if.slave  bus
);

  // --------------------------------------------------------------------------
  // State encoding
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SERVE = 2'd1,
    ST_ACK   = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  state_t            state_q,      state_d;
  logic              winner_q,     winner_d;      // port currently being served
  logic              last_grant_q, last_grant_d;  // port granted most recently
  logic              err_q,        err_d;         // winner's address misaligned
  logic [DATA_W-1:0] rdata_q,      rdata_d;       // read-data holding register

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic              w_any_req;
  logic              w_grant_sel;   // candidate winner while in IDLE
  logic [ADDR_W-1:0] w_grant_addr;  // candidate winner's address
  logic              w_sel_wr;      // winner's request, muxed by winner_q
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;
  logic              w_serving;
  logic              w_acking;

  assign w_any_req = bus.req0 | bus.req1;
  assign w_serving = (state_q == ST_SERVE);
  assign w_acking  = (state_q == ST_ACK);

  // Round-robin pick. On a tie the port that did not win last time gets the
  // grant; last_grant resets to 1 so port 0 takes the first tie.
  always_comb begin
    w_grant_sel = 1'b0;
    if (bus.req0 && bus.req1) begin
      w_grant_sel = ~last_grant_q;
    end else if (bus.req1) begin
      w_grant_sel = 1'b1;
    end
    w_grant_addr = w_grant_sel ? bus.addr1 : bus.addr0;
  end

  // Request fields of the port that won arbitration. Requesters keep these
  // stable while req is high, so no copy is stored here.
  always_comb begin
    w_sel_wr    = bus.wr0;
    w_sel_addr  = bus.addr0;
    w_sel_wdata = bus.wdata0;
    if (winner_q) begin
      w_sel_wr    = bus.wr1;
      w_sel_addr  = bus.addr1;
      w_sel_wdata = bus.wdata1;
    end
  end

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      winner_q     <= 1'b0;
      last_grant_q <= 1'b1;
      err_q        <= 1'b0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      winner_q     <= winner_d;
      last_grant_q <= last_grant_d;
      err_q        <= err_d;
      rdata_q      <= rdata_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    winner_d     = winner_q;
    last_grant_d = last_grant_q;
    err_d        = err_q;
    rdata_d      = rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (w_any_req) begin
          winner_d     = w_grant_sel;
          last_grant_d = w_grant_sel;
          // A misaligned access still walks through SERVE/ACK so the
          // requester gets its ack, but the strobes stay off.
          err_d        = |w_grant_addr[1:0];
          state_d      = ST_SERVE;
        end
      end

      ST_SERVE: begin
        // Memory read is combinational; capture on the edge closing SERVE.
        if (!w_sel_wr && !err_q) begin
          rdata_d = bus.mem_read_data;
        end
        state_d = ST_ACK;
      end

      ST_ACK: begin
        // The acked port's req is deliberately not looked at here; the
        // requester drops or renews it on the edge leaving ACK.
        err_d   = 1'b0;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs, decoded from the current state only so that an asynchronous
  // reset clears every strobe and ack without waiting for a clock edge.
  // --------------------------------------------------------------------------
  always_comb begin
    bus.mem_address    = '0;
    bus.mem_write_data = '0;
    bus.mem_write      = 1'b0;
    bus.mem_read       = 1'b0;
    if (w_serving) begin
      bus.mem_address    = w_sel_addr;
      bus.mem_write_data = w_sel_wdata;
      bus.mem_write      =  w_sel_wr & ~err_q;
      bus.mem_read       = ~w_sel_wr & ~err_q;
    end
  end

  always_comb begin
    bus.ack0 = w_acking & ~winner_q;
    bus.ack1 = w_acking &  winner_q;
    bus.err0 = w_acking & ~winner_q & err_q;
    bus.err1 = w_acking &  winner_q & err_q;
  end

  assign bus.rdata = rdata_q;

endmodule : dmem_arbiter
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_arbiter
//  Description : Self-checking bench for dmem_arbiter. Models DataMemory as a
//                64-word array, applies a table of single-port transactions,
//                then hand-written sequences for reset, contention and
//                round-robin alternation.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

  logic clk;
  logic rst;
  logic mem_init;

  int n_checks = 0;
  int n_errors = 0;

  dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DataMemory model: combinational read, write on rising edge.
  logic [31:0] tb_mem [0:63];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int k = 0; k < 64; k++) tb_mem[k] <= 32'h0;
    end else if (bus.mem_write) begin
      tb_mem[bus.mem_address[7:2]] <= bus.mem_write_data;
    end
  end
  assign bus.mem_read_data = tb_mem[bus.mem_address[7:2]];

  // --------------------------------------------------------------------------
  // Checking helpers
  // --------------------------------------------------------------------------
  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual %h required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual %b required %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string name);
    check1 (name, bus.ack0 | bus.ack1 | bus.err0 | bus.err1 | bus.mem_write | bus.mem_read, 1'b0);
    check32(name, bus.rdata, 32'h0);
    check32(name, bus.mem_address | bus.mem_write_data, 32'h0);
  endtask

  task automatic set_req(input logic port, input logic val, input logic wr,
                         input logic [31:0] addr, input logic [31:0] wdata);
    if (port == 1'b0) begin
      bus.req0 = val; bus.wr0 = wr; bus.addr0 = addr; bus.wdata0 = wdata;
    end else begin
      bus.req1 = val; bus.wr1 = wr; bus.addr1 = addr; bus.wdata1 = wdata;
    end
  endtask

  // --------------------------------------------------------------------------
  // Vector table
  // --------------------------------------------------------------------------
  typedef struct {
    logic        port;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [9];

  // Runs one transaction; entered and left just after a rising edge in IDLE.
  task automatic run_txn(input vec_t v);
    logic own_ack, oth_ack, own_err;
    set_req(v.port, 1'b1, v.wr, v.addr, v.wdata);
    @(negedge clk);  // IDLE: request not yet sampled
    check1("idle_ack", bus.ack0 | bus.ack1, 1'b0);
    check1("idle_strobe", bus.mem_write | bus.mem_read, 1'b0);
    @(negedge clk);  // SERVE
    check1("serve_we", bus.mem_write, v.wr & ~v.exp_err);
    check1("serve_re", bus.mem_read, ~v.wr & ~v.exp_err);
    check1("serve_ack", bus.ack0 | bus.ack1, 1'b0);
    if (!v.exp_err) check32("serve_addr", bus.mem_address, v.addr);
    if (v.wr && !v.exp_err) check32("serve_wdata", bus.mem_write_data, v.wdata);
    @(negedge clk);  // ACK
    own_ack = v.port ? bus.ack1 : bus.ack0;
    oth_ack = v.port ? bus.ack0 : bus.ack1;
    own_err = v.port ? bus.err1 : bus.err0;
    check1 ("ack_own", own_ack, 1'b1);
    check1 ("ack_other", oth_ack, 1'b0);
    check1 ("ack_err", own_err, v.exp_err);
    check32("ack_rdata", bus.rdata, v.exp_rdata);
    check1 ("ack_strobe", bus.mem_write | bus.mem_read, 1'b0);
    @(posedge clk); #1;
    set_req(v.port, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //               port  wr    addr          wdata         err   rdata
    vecs[0] = '{1'b0, 1'b1, 32'h0000_0010, 32'hDEADBEEF, 1'b0, 32'h0000_0000};
    vecs[1] = '{1'b0, 1'b0, 32'h0000_0010, 32'h0,        1'b0, 32'hDEADBEEF};
    vecs[2] = '{1'b1, 1'b1, 32'h0000_0014, 32'hCAFEF00D, 1'b0, 32'hDEADBEEF};
    vecs[3] = '{1'b1, 1'b0, 32'h0000_0014, 32'h0,        1'b0, 32'hCAFEF00D};
    vecs[4] = '{1'b1, 1'b0, 32'h0000_0013, 32'h0,        1'b1, 32'hCAFEF00D};
    vecs[5] = '{1'b0, 1'b1, 32'h0000_0012, 32'h12345678, 1'b1, 32'hCAFEF00D};
    vecs[6] = '{1'b0, 1'b0, 32'h0000_0010, 32'h0,        1'b0, 32'hDEADBEEF};
    vecs[7] = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,        1'b0, 32'h0000_0000};
    vecs[8] = '{1'b0, 1'b0, 32'h0000_0011, 32'h0,        1'b1, 32'h0000_0000};

    rst = 1'b1;
    mem_init = 1'b1;
    set_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_req(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1 mem_init = 1'b0;
    @(negedge clk);
    check_all_zero("reset_state");
    @(posedge clk); #1 rst = 1'b0;

    // ---------------- table-driven single transactions ----------------
    for (int i = 0; i < 9; i++) run_txn(vecs[i]);

    // ---------------- reset asserted mid-SERVE, req0 held ----------------
    set_req(1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
    @(negedge clk);
    @(negedge clk);
    check1("rstA_serve_re", bus.mem_read, 1'b1);
    #1 rst = 1'b1;
    #1 check_all_zero("rstA_async_clear");
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check1("rstA_idle_re", bus.mem_read | bus.mem_write, 1'b0);
    check1("rstA_idle_ack", bus.ack0 | bus.ack1, 1'b0);
    @(negedge clk);
    check1 ("rstA_serve2_re", bus.mem_read, 1'b1);
    check32("rstA_serve2_addr", bus.mem_address, 32'h10);
    @(negedge clk);
    check1 ("rstA_ack0", bus.ack0, 1'b1);
    check32("rstA_rdata", bus.rdata, 32'hDEADBEEF);
    @(posedge clk); #1;
    set_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

    // ---------------- both ports requesting from reset release ----------------
    rst = 1'b1;
    set_req(1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
    set_req(1'b1, 1'b1, 1'b0, 32'h14, 32'h0);
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      logic        e_ack0, e_ack1;
      logic [31:0] e_addr;
      @(negedge clk);
      e_ack0 = (i == 3) || (i == 9);
      e_ack1 = (i == 6) || (i == 12);
      e_addr = ((i == 2) || (i == 8))  ? 32'h10 :
               ((i == 5) || (i == 11)) ? 32'h14 : 32'h0;
      check1 ("rr_ack0", bus.ack0, e_ack0);
      check1 ("rr_ack1", bus.ack1, e_ack1);
      check1 ("rr_no_overlap", bus.ack0 & bus.ack1, 1'b0);
      check32("rr_addr", bus.mem_address, e_addr);
      if (e_ack0) check32("rr_rdata0", bus.rdata, 32'hDEADBEEF);
      if (e_ack1) check32("rr_rdata1", bus.rdata, 32'hCAFEF00D);
    end
    @(posedge clk); #1;
    set_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_req(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);

    // ---------------- contention: p0 writes 0x20, p1 reads 0x20 ----------------
    // Port 1 won last, so port 0 takes this tie.
    set_req(1'b0, 1'b1, 1'b1, 32'h20, 32'h11111111);
    set_req(1'b1, 1'b1, 1'b0, 32'h20, 32'h0);
    @(negedge clk);
    @(negedge clk);
    check1 ("ct_serve0_we", bus.mem_write, 1'b1);
    check32("ct_serve0_wd", bus.mem_write_data, 32'h11111111);
    @(negedge clk);
    check1("ct_ack0", bus.ack0, 1'b1);
    check1("ct_ack1_pending", bus.ack1, 1'b0);
    @(posedge clk); #1;
    set_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    check1("ct_idle_ack", bus.ack0 | bus.ack1, 1'b0);
    @(negedge clk);
    check1("ct_serve1_re", bus.mem_read, 1'b1);
    @(negedge clk);
    check1 ("ct_ack1", bus.ack1, 1'b1);
    check32("ct_rdata", bus.rdata, 32'h11111111);
    @(posedge clk); #1;
    set_req(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);

    // ---------------- reset during SERVE of a write to 0x30 ----------------
    set_req(1'b0, 1'b1, 1'b1, 32'h30, 32'h5A5A5A5A);
    @(negedge clk);
    @(negedge clk);
    check1("rstD_serve_we", bus.mem_write, 1'b1);
    #1 rst = 1'b1;
    set_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    #1 check1("rstD_we_drop", bus.mem_write, 1'b0);
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check1("rstD_no_ack", bus.ack0 | bus.ack1, 1'b0);
    end
    check32("rstD_mem30", tb_mem[12], 32'h0);
    @(posedge clk); #1;
    run_txn('{1'b0, 1'b0, 32'h30, 32'h0, 1'b0, 32'h0});

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_dmem_arbiter
`default_nettype wire
